// File: rtl/flagram_seq.sv
// Request sequencer for the flagram 16x4 flag memory: one command per handshake, fixed strobe timing.
// Build option FLAGRAM_SEQ_VERIFY_EN adds o_w_rsp_err (write-verify compare result).
module flagram_seq #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
) (
  input  logic              i_w_clk,
  input  logic              i_w_reset,
  input  logic              i_w_req_valid,
  output logic              o_w_req_ready,
  input  logic [1:0]        i_w_req_op,
  input  logic [ADDR_W-1:0] i_w_req_addr,
  input  logic [DATA_W-1:0] i_w_req_data,
  output logic              o_w_rsp_valid,
  input  logic              i_w_rsp_ready,
  output logic [DATA_W-1:0] o_w_rsp_data,
  output logic [DATA_W-1:0] o_w_rsp_flags,
  output logic [ADDR_W-1:0] o_w_ram_address,
  output logic [DATA_W-1:0] o_w_ram_data,
  output logic              o_w_ram_we,
  output logic              o_w_ram_oe,
  output logic              o_w_ram_flags_out,
  input  logic [DATA_W-1:0] i_w_ram_out
`ifdef FLAGRAM_SEQ_VERIFY_EN
  ,
  output logic              o_w_rsp_err
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_RD_CAP,
    S_FL,
    S_FL_CAP,
    S_RSP
  } state_t;

  typedef enum logic [1:0] {
    OP_WRITE   = 2'b00,
    OP_READ    = 2'b01,
    OP_FLAGS   = 2'b10,
    OP_WVERIFY = 2'b11
  } op_t;

  state_t              state;
  op_t                 op_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   data_q;
  logic [DATA_W-1:0]   flags_q;

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge i_w_clk) begin
    if (i_w_reset) begin
      state   <= S_IDLE;
      op_q    <= OP_WRITE;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      flags_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_w_req_valid) begin
            op_q    <= op_t'(i_w_req_op);
            addr_q  <= i_w_req_addr;
            wdata_q <= i_w_req_data;
            // The field an op does not fetch is zeroed so responses never carry stale words.
            if (i_w_req_op == OP_FLAGS) data_q  <= '0;
            if (i_w_req_op == OP_READ)  flags_q <= '0;
            case (op_t'(i_w_req_op))
              OP_WRITE:   state <= S_WR;
              OP_READ:    state <= S_RD;
              OP_FLAGS:   state <= S_FL;
              OP_WVERIFY: state <= S_WR;
              default:    state <= S_IDLE;
            endcase
          end
        end
        S_WR:     state <= (op_q == OP_WVERIFY) ? S_RD : S_IDLE;
        S_RD:     state <= S_RD_CAP;
        S_RD_CAP: begin
          data_q <= i_w_ram_out;
          state  <= (op_q == OP_WVERIFY) ? S_FL : S_RSP;
        end
        S_FL:     state <= S_FL_CAP;
        S_FL_CAP: begin
          flags_q <= i_w_ram_out;
          state   <= S_RSP;
        end
        S_RSP:    if (i_w_rsp_ready) state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  // Two-cycle oe/flags_out windows serve both combinational- and registered-read RAMs.
  assign o_w_ram_we        = (state == S_WR);
  assign o_w_ram_oe        = (state == S_RD) || (state == S_RD_CAP);
  assign o_w_ram_flags_out = (state == S_FL) || (state == S_FL_CAP);
  assign o_w_ram_address   = addr_q;
  assign o_w_ram_data      = wdata_q;

  // Handshake outputs are masked by reset so nothing is offered or accepted while it is held;
  // RAM strobes are not, so a write already in WR still lands.
  assign o_w_req_ready = (state == S_IDLE) && !i_w_reset;
  assign o_w_rsp_valid = (state == S_RSP) && !i_w_reset;
  assign o_w_rsp_data  = data_q;
  assign o_w_rsp_flags = flags_q;

`ifdef FLAGRAM_SEQ_VERIFY_EN
  assign o_w_rsp_err = o_w_rsp_valid && (op_q == OP_WVERIFY) && (data_q != wdata_q);
`endif

  a_strobe_excl: assert property (@(posedge i_w_clk) disable iff (i_w_reset)
    $onehot0({o_w_ram_we, o_w_ram_oe, o_w_ram_flags_out}));

  a_strobe_quiet: assert property (@(posedge i_w_clk) disable iff (i_w_reset)
    (state == S_IDLE || state == S_RSP) |-> !(o_w_ram_we || o_w_ram_oe || o_w_ram_flags_out));

  a_rsp_hold: assert property (@(posedge i_w_clk) disable iff (i_w_reset)
    (o_w_rsp_valid && !i_w_rsp_ready) |=>
      (o_w_rsp_valid && $stable(o_w_rsp_data) && $stable(o_w_rsp_flags)));

endmodule

// File: tb/tb_flagram_seq.sv
// Self-checking bench for flagram_seq with a behavioural flagram stand-in and a response scoreboard.
// Define FLAGRAM_SEQ_VERIFY_EN for both files to exercise the write-verify error output.
module tb_flagram_seq;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [3:0] req_addr;
  logic [3:0] req_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_data;
  logic [3:0] rsp_flags;
  logic [3:0] ram_addr;
  logic [3:0] ram_data;
  logic       ram_we;
  logic       ram_oe;
  logic       ram_fl;
  logic [3:0] ram_out;
`ifdef FLAGRAM_SEQ_VERIFY_EN
  logic       rsp_err;
  localparam logic [3:0] STUB_XOR = 4'h1;
`else
  localparam logic [3:0] STUB_XOR = 4'h0;
`endif

  flagram_seq dut (
    .i_w_clk           (clk),
    .i_w_reset         (rst),
    .i_w_req_valid     (req_valid),
    .o_w_req_ready     (req_ready),
    .i_w_req_op        (req_op),
    .i_w_req_addr      (req_addr),
    .i_w_req_data      (req_data),
    .o_w_rsp_valid     (rsp_valid),
    .i_w_rsp_ready     (rsp_ready),
    .o_w_rsp_data      (rsp_data),
    .o_w_rsp_flags     (rsp_flags),
    .o_w_ram_address   (ram_addr),
    .o_w_ram_data      (ram_data),
    .o_w_ram_we        (ram_we),
    .o_w_ram_oe        (ram_oe),
    .o_w_ram_flags_out (ram_fl),
    .i_w_ram_out       (ram_out)
`ifdef FLAGRAM_SEQ_VERIFY_EN
    ,
    .o_w_rsp_err       (rsp_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // flagram stand-in: combinational read, flag word stored as ~data, optional data corruption.
  logic [3:0] ram_mem [16];
  logic [3:0] ram_flg [16];
  always @(posedge clk) begin
    if (ram_we) begin
      ram_mem[ram_addr] <= ram_data;
      ram_flg[ram_addr] <= ~ram_data;
    end
  end
  always_comb begin
    ram_out = 4'h0;
    if (ram_oe)      ram_out = ram_mem[ram_addr] ^ STUB_XOR;
    else if (ram_fl) ram_out = ram_flg[ram_addr];
  end

  typedef struct {
    logic [3:0] data;
    logic [3:0] flags;
    logic       err;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] ref_mem [16];
  logic [3:0] ref_flg [16];
  logic [3:0] cur_addr = 4'h0;
  logic [3:0] cur_data = 4'h0;
  int         checks = 0;
  int         failures = 0;
  int         acc_cyc = 0;
  logic [15:0] trace_code = 16'h0;
  int         trace_len = 0;
  logic [3:0] we_addr = 4'h0;
  logic [3:0] we_data = 4'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] outs_vec();
    logic [31:0] v;
    v = 32'({req_ready, rsp_valid, rsp_data, rsp_flags, ram_addr, ram_data, ram_we, ram_oe, ram_fl});
`ifdef FLAGRAM_SEQ_VERIFY_EN
    v[31] = rsp_err;
`endif
    return v;
  endfunction

  function automatic logic [31:0] trace_word();
    return (32'(trace_len) << 16) | 32'(trace_code);
  endfunction

  task automatic clear_trace();
    trace_code = 16'h0;
    trace_len  = 0;
  endtask

  // Reference model: update memory image and push the expected response at the accept edge.
  task automatic model_accept(input logic [1:0] op, input logic [3:0] a, input logic [3:0] d);
    exp_t e;
    cur_addr = a;
    cur_data = d;
    case (op)
      2'b00: begin
        ref_mem[a] = d;
        ref_flg[a] = ~d;
      end
      2'b01: begin
        e.data = ref_mem[a] ^ STUB_XOR; e.flags = 4'h0; e.err = 1'b0;
        sb.push_back(e);
      end
      2'b10: begin
        e.data = 4'h0; e.flags = ref_flg[a]; e.err = 1'b0;
        sb.push_back(e);
      end
      default: begin
        ref_mem[a] = d;
        ref_flg[a] = ~d;
        e.data = d ^ STUB_XOR; e.flags = ~d; e.err = (STUB_XOR != 4'h0);
        sb.push_back(e);
      end
    endcase
  endtask

  task automatic send(input logic [1:0] op, input logic [3:0] a, input logic [3:0] d);
    bit ok;
    ok = 1'b0;
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = a;
    req_data  = d;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        model_accept(op, a, d);
      end
      tick();
    end
    req_valid = 1'b0;
    acc_cyc = cyc;
    check("accept", 32'(ok), 32'd1);
  endtask

  // Leaves the caller at the negedge of the first rsp_valid cycle.
  task automatic wait_rsp(input string tag, input int exp_lat);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 20);
    check(tag, 32'(n), 32'(exp_lat));
  endtask

  // Monitor: strobe sanity, RAM-side address/data, strobe trace, hold stability, scoreboard pops.
  initial begin
    bit         prev_valid;
    bit         prev_hs;
    logic [7:0] prev_word;
    exp_t       e;
    prev_valid = 1'b0;
    prev_hs    = 1'b0;
    prev_word  = 8'h0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 1'b0;
      end else begin
        check("strobe_excl", 32'((int'(ram_we) + int'(ram_oe) + int'(ram_fl)) <= 1), 32'd1);
        if (ram_we || ram_oe || ram_fl) begin
          check("ram_addr", 32'(ram_addr), 32'(cur_addr));
          check("ram_data", 32'(ram_data), 32'(cur_data));
          trace_code = (trace_code << 2) | (ram_we ? 16'd1 : ram_oe ? 16'd2 : 16'd3);
          trace_len++;
          if (ram_we) begin
            we_addr = ram_addr;
            we_data = ram_data;
          end
        end
        if (prev_valid && !prev_hs) begin
          check("rsp_hold_valid", 32'(rsp_valid), 32'd1);
          check("rsp_hold_word", 32'({rsp_data, rsp_flags}), 32'(prev_word));
        end
        if (rsp_valid && rsp_ready) begin
          check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            check("rsp_data", 32'(rsp_data), 32'(e.data));
            check("rsp_flags", 32'(rsp_flags), 32'(e.flags));
`ifdef FLAGRAM_SEQ_VERIFY_EN
            check("rsp_err", 32'(rsp_err), 32'(e.err));
`endif
          end
        end
        prev_valid = rsp_valid;
        prev_hs    = rsp_valid && rsp_ready;
        prev_word  = {rsp_data, rsp_flags};
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int c1;
    int seen;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_addr  = 4'h0;
    req_data  = 4'h0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ram_mem[i] = 4'h0; ram_flg[i] = 4'h0;
      ref_mem[i] = 4'h0; ref_flg[i] = 4'h0;
    end

    // Reset held for two edges; everything quiet, ready only after release.
    tick();
    @(negedge clk);
    check("reset_outs", outs_vec(), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 32'(req_ready), 32'd1);
    tick();

    // Plain write: one we cycle, no response, ready again two cycles after accept.
    clear_trace();
    send(2'b00, 4'h3, 4'hA);
    @(negedge clk);
    check("wr_busy", 32'(req_ready), 32'd0);
    tick();
    @(negedge clk);
    check("wr_ready_2cyc", 32'(req_ready), 32'd1);
    check("wr_trace", trace_word(), 32'h0001_0001);
    check("wr_addr", 32'(we_addr), 32'h3);
    check("wr_data", 32'(we_data), 32'hA);
    tick();

    // Read back: oe for two cycles, response on cycle 3.
    clear_trace();
    send(2'b01, 4'h3, 4'h0);
    wait_rsp("rd_lat", 3);
    tick();
    check("rd_trace", trace_word(), 32'h0002_000A);

    // Flag read.
    clear_trace();
    send(2'b10, 4'h3, 4'h0);
    wait_rsp("fl_lat", 3);
    tick();
    check("fl_trace", trace_word(), 32'h0002_000F);

    // Write-verify with consumer stalled: five strobe cycles (we,oe,oe,fl,fl) precede RSP,
    // so rsp_valid first shows on cycle 6; response held and no new accept while stalled.
    rsp_ready = 1'b0;
    clear_trace();
    send(2'b11, 4'hF, 4'h5);
    wait_rsp("wv_lat", 6);
    for (int i = 0; i < 4; i++) begin
      check("wv_ready_low", 32'(req_ready), 32'd0);
      tick();
      @(negedge clk);
    end
    tick();
    rsp_ready = 1'b1;
    tick();
    check("wv_trace", trace_word(), 32'h0005_01AF);
    @(negedge clk);
    check("wv_ready_after", 32'(req_ready), 32'd1);
    tick();

    // Write-verify then read on another address (data^1 stub when the verify option is built).
    send(2'b11, 4'h2, 4'h6);
    wait_rsp("wv2_lat", 6);
    tick();
    send(2'b01, 4'h2, 4'h0);
    wait_rsp("rd2_lat", 3);
    tick();

    // Back-to-back reads with the next request already waiting: one accept per 4 cycles.
    send(2'b01, 4'h3, 4'h0);
    c1 = acc_cyc;
    send(2'b01, 4'hF, 4'h0);
    check("rd_b2b_spacing", 32'(acc_cyc - c1), 32'd4);
    wait_rsp("rd_b2b_lat", 3);
    tick();

    // Back-to-back writes: one accept per 2 cycles.
    send(2'b00, 4'h1, 4'h1);
    c1 = acc_cyc;
    send(2'b00, 4'h7, 4'h9);
    check("wr_b2b_spacing", 32'(acc_cyc - c1), 32'd2);
    tick();

    // Reset during RD_CAP: dropped, IDLE next cycle, never a response.
    send(2'b01, 4'h7, 4'h0);
    tick();
    rst = 1'b1;
    sb.delete();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_idle_ready", 32'(req_ready), 32'd1);
    check("rst_idle_oe", 32'(ram_oe), 32'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (rsp_valid) seen++;
      tick();
      @(negedge clk);
    end
    check("rst_no_rsp", 32'(seen), 32'd0);
    tick();
    send(2'b01, 4'h7, 4'h0);
    wait_rsp("rd_after_rst_lat", 3);
    tick();

    // Reset sampled during WR: that write still lands.
    send(2'b00, 4'h4, 4'hC);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    send(2'b01, 4'h4, 4'h0);
    wait_rsp("rd_wr_rst_lat", 3);
    tick();

    repeat (3) tick();
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
